subservient_gpio_in: RTL and testbench
======================================

# subservient_gpio_in

Debounced, edge-capturing GPIO input port for the subservient SoC, sitting on the same Wishbone peripheral bus as the GPIO output register and feeding pin state and edge events back to the core. Each external pin is synchronised, optionally debounced, and monitored for rising and falling edges. Captured edges are held in sticky write-1-to-clear registers and can raise a level interrupt.

## Interface
- WIDTH, 5: number of input pins.
- DEBOUNCE_CYCLES, 8: consecutive cycles a new synchronised level must persist before acceptance; legal range 1..256.
- i_wb_clk  input  1  system clock; all logic on rising edge.
- i_wb_rst_n  input  1  asynchronous, active-low reset; one clock domain.
- i_wb_adr  input  2  register select: 0 STATE, 1 RISE, 2 FALL, 3 IEN.
- i_wb_dat  input  WIDTH  write data.
- i_wb_we  input  1  write strobe qualifier.
- i_wb_stb  input  1  bus cycle request.
- o_wb_rdt  output  WIDTH  read data; valid while o_wb_ack is high.
- o_wb_ack  output  1  single-cycle acknowledge.
- i_gpio  input  WIDTH  asynchronous external pins.
- o_irq  output  1  registered interrupt, high while any enabled edge flag is set.

## Operation
- Synchroniser: two flops per pin (s1, s2); reset 0.
- Stable register `stable[WIDTH]`, reset 0, is the debounced pin value.
- Debounce (macro defined): per-pin counter `cnt`, width clog2(DEBOUNCE_CYCLES), reset 0.
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never reaches stable.
- Edge flags RISE/FALL (reset 0): bit set in the cycle after stable goes 0->1 / 1->0. This is a compare of stable against its one-cycle-delayed copy `stable_q`, which resets to 0.
- Register map:
  - STATE: read-only stable; writes ignored.
  - RISE, FALL: read flags; writing 1 clears the bit, writing 0 has no effect.
  - IEN: read/write per-pin enable, reset 0.
- Flag boundary rule: a set and a clear of the same bit in the same cycle leaves the bit set (set wins).
- Wishbone access:
  - o_wb_ack <= i_wb_stb & !o_wb_ack.
  - Writes take effect only on the request cycle (i_wb_stb & i_wb_we & !o_wb_ack). Exactly one write per access.
  - o_wb_rdt <= mux(i_wb_adr) every cycle; reads have no side effects.
- o_irq <= |((RISE | FALL) & IEN); reset 0.
- Reset asserted mid-operation clears every flop asynchronously, including any in-flight ack. After release, the bench must see no spurious edge flag unless a pin is high (0->1 rise on stable is legitimate).

## Timing
- Reset values: o_wb_rdt 0, o_wb_ack 0, o_irq 0, all internal state 0.
- Bus latency: ack and read data arrive one cycle after stb rises; back-to-back stb yields ack on alternate cycles.
- Pin-to-stable latency (edges counted from first edge sampling new pin level):
  - Debounce on: 2 + DEBOUNCE_CYCLES edges.
  - Debounce off: 3 edges.
- Stable-to-flag: +1 edge. Flag-to-o_irq: +1 edge.
- Write-to-clear: flag reads 0 on the access following the one that cleared it. o_irq falls one cycle after the flag clears.

## Configuration
- SUBSERVIENT_GPIO_IN_DEBOUNCE_EN:
  - Defined: per-pin debounce counters as above; DEBOUNCE_CYCLES honoured.
  - Undefined: no counters; stable <= s2 every cycle; DEBOUNCE_CYCLES ignored.

## Test plan
- Reset: hold i_wb_rst_n low with i_gpio=5'h1F, release. Read STATE -> 5'h1F after latency. RISE -> 5'h1F; FALL -> 0; o_irq stays 0 (IEN=0).
- Debounce (macro on, DEBOUNCE_CYCLES=8):
  - Pulse i_gpio[2] high for 5 cycles -> STATE[2] stays 0, RISE stays 0.
  - Hold high -> STATE[2]=1 exactly 10 edges after first sampling.
- Debounce (macro off): toggle i_gpio[0] 0->1 -> STATE[0]=1 after 3 edges. RISE[0]=1 one edge later.
- Interrupt:
  - Write IEN=5'h04, drive i_gpio[2] 1->0 -> FALL=5'h04 and o_irq=1.
  - Write FALL=5'h04 -> FALL=0; o_irq=0 one cycle later.
- Set-wins race: write RISE=5'h02 in the same cycle a new rise on pin 1 lands -> RISE[1] reads 1.
- Bus protocol: hold stb high 6 cycles with we=1, adr=3, dat=5'h1B -> ack pattern 0,1,0,1,0,1; IEN reads 5'h1B; async reset mid-access drops ack immediately.

Source files
------------

// File: rtl/subservient_gpio_in.sv
// subservient_gpio_in: Wishbone GPIO input port with synchronisers, optional
// debounce, sticky write-1-to-clear rise/fall flags and a level interrupt.
// Build option: define SUBSERVIENT_GPIO_IN_DEBOUNCE_EN to add per-pin debounce
// counters; without it the synchronised level is accepted every cycle.
// Register map: 0 STATE (ro), 1 RISE (w1c), 2 FALL (w1c), 3 IEN (rw).
module subservient_gpio_in #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst_n,
    input  logic [1:0]       i_wb_adr,
    input  logic [WIDTH-1:0] i_wb_dat,
    input  logic             i_wb_we,
    input  logic             i_wb_stb,
    output logic [WIDTH-1:0] o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic             o_irq
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 256) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..256");
    end

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] rdt_q, rdt_d;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;

    logic             wr_req;
    logic [WIDTH-1:0] clr_rise;
    logic [WIDTH-1:0] clr_fall;

    // Two-flop synchroniser and one-cycle delayed copy of the accepted level
    always_comb begin
        s1_d         = i_gpio;
        s2_d         = s1_q;
        stable_dly_d = stable_q;
    end

`ifdef SUBSERVIENT_GPIO_IN_DEBOUNCE_EN
    // Counter width is at least one bit so DEBOUNCE_CYCLES=1 still elaborates
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: a differing level must persist DEBOUNCE_CYCLES cycles to be accepted
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce counter registers
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without debounce the synchronised level is taken directly
    always_comb begin
        stable_d = s2_q;
    end
`endif

    // Bus decode, sticky edge flags (set wins over clear), read mux and interrupt
    always_comb begin
        wr_req   = i_wb_stb & i_wb_we & ~ack_q;
        clr_rise = (wr_req && i_wb_adr == 2'd1) ? i_wb_dat : '0;
        clr_fall = (wr_req && i_wb_adr == 2'd2) ? i_wb_dat : '0;

        rise_d = (rise_q & ~clr_rise) | (stable_q & ~stable_dly_q);
        fall_d = (fall_q & ~clr_fall) | (~stable_q & stable_dly_q);
        ien_d  = (wr_req && i_wb_adr == 2'd3) ? i_wb_dat : ien_q;

        rdt_d = '0;
        case (i_wb_adr)
            2'd0:    rdt_d = stable_q;
            2'd1:    rdt_d = rise_q;
            2'd2:    rdt_d = fall_q;
            default: rdt_d = ien_q;
        endcase

        ack_d = i_wb_stb & ~ack_q;
        irq_d = |((rise_q | fall_q) & ien_q);
    end

    // State registers
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            ien_q        <= '0;
            rdt_q        <= '0;
            ack_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            ien_q        <= ien_d;
            rdt_q        <= rdt_d;
            ack_q        <= ack_d;
            irq_q        <= irq_d;
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = ack_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_subservient_gpio_in.sv
// Bench for subservient_gpio_in: reference model driven from pin history,
// table of bus vectors, directed latency/race/reset sequences, random phase.
module tb_subservient_gpio_in;

    localparam int W  = 5;
    localparam int D  = 8;
    localparam int HN = D + 2;
`ifdef SUBSERVIENT_GPIO_IN_DEBOUNCE_EN
    localparam int LAT = 2 + D;
`else
    localparam int LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   adr = '0;
    logic [W-1:0] dat = '0;
    logic         we = 1'b0;
    logic         stb = 1'b0;
    logic [W-1:0] rdt;
    logic         ack;
    logic [W-1:0] gpio = '0;
    logic         irq;

    int checks = 0;
    int failures = 0;

    subservient_gpio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_adr   (adr),
        .i_wb_dat   (dat),
        .i_wb_we    (we),
        .i_wb_stb   (stb),
        .o_wb_rdt   (rdt),
        .o_wb_ack   (ack),
        .i_gpio     (gpio),
        .o_irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model. hist[k] is the pin value sampled k+1 edges ago; the
    // accepted level flips once the synchronised pin has disagreed with it for
    // D consecutive cycles (or immediately, two samples late, without debounce).
    logic [W-1:0] hist [0:HN-1];
    logic [W-1:0] m_stable, m_stable_dly, m_rise, m_fall, m_ien, m_rdt;
    logic         m_ack, m_irq;

    function automatic logic [W-1:0] next_stable();
        logic [W-1:0] n;
        n = m_stable;
`ifdef SUBSERVIENT_GPIO_IN_DEBOUNCE_EN
        for (int b = 0; b < W; b++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
                if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) n[b] = ~m_stable[b];
        end
`else
        n = hist[1];
`endif
        return n;
    endfunction

    function automatic logic [W-1:0] clr_mask(input logic [1:0] a);
        return (stb && we && !m_ack && adr == a) ? dat : '0;
    endfunction

    function automatic logic [W-1:0] read_mux();
        case (adr)
            2'd0:    return m_stable;
            2'd1:    return m_rise;
            2'd2:    return m_fall;
            default: return m_ien;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < HN; j++) hist[j] <= '0;
            m_stable     <= '0;
            m_stable_dly <= '0;
            m_rise       <= '0;
            m_fall       <= '0;
            m_ien        <= '0;
            m_rdt        <= '0;
            m_ack        <= 1'b0;
            m_irq        <= 1'b0;
        end else begin
            for (int j = HN - 1; j > 0; j--) hist[j] <= hist[j-1];
            hist[0]      <= gpio;
            m_stable     <= next_stable();
            m_stable_dly <= m_stable;
            m_rise       <= (m_rise & ~clr_mask(2'd1)) | (m_stable & ~m_stable_dly);
            m_fall       <= (m_fall & ~clr_mask(2'd2)) | (~m_stable & m_stable_dly);
            m_ien        <= (stb && we && !m_ack && adr == 2'd3) ? dat : m_ien;
            m_rdt        <= read_mux();
            m_ack        <= stb & ~m_ack;
            m_irq        <= |((m_rise | m_fall) & m_ien);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("model_ack", W'(ack), W'(m_ack));
        check("model_irq", W'(irq), W'(m_irq));
        if (m_ack) check("model_rdt", rdt, m_rdt);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        stb = 1'b1; we = 1'b1; adr = a; dat = d;
        tick();
        check("wr_ack", W'(ack), W'(1));
        stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [W-1:0] d);
        stb = 1'b1; we = 1'b0; adr = a; dat = '0;
        tick();
        check("rd_ack", W'(ack), W'(1));
        d = rdt;
        stb = 1'b0;
        tick();
    endtask

    // Pin idx goes high: irq (IEN on that pin only) must rise exactly LAT+2 edges later
    task automatic latency_check(input int idx);
        logic [W-1:0] mask;
        logic [W-1:0] d;
        mask = W'(1) << idx;
        bus_write(2'd3, mask);
        bus_write(2'd1, '1);
        bus_write(2'd2, '1);
        check("lat_irq_pre", W'(irq), W'(0));
        gpio[idx] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (k == LAT + 1) check("lat_irq_early", W'(irq), W'(0));
            if (k == LAT + 2) check("lat_irq_on", W'(irq), W'(1));
        end
        bus_read(2'd0, d);
        check("lat_state", d & mask, mask);
        bus_read(2'd1, d);
        check("lat_rise", d & mask, mask);
    endtask

    typedef struct {
        logic         we;
        logic [1:0]   adr;
        logic [W-1:0] dat;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [W-1:0] d;
        int b;

        vecs[0] = '{1'b1, 2'd3, 5'h1B, 5'h00};
        vecs[1] = '{1'b0, 2'd3, 5'h00, 5'h1B};
        vecs[2] = '{1'b1, 2'd0, 5'h1F, 5'h00};
        vecs[3] = '{1'b0, 2'd0, 5'h00, 5'h00};
        vecs[4] = '{1'b1, 2'd1, 5'h1F, 5'h00};
        vecs[5] = '{1'b0, 2'd1, 5'h00, 5'h00};
        vecs[6] = '{1'b0, 2'd2, 5'h00, 5'h00};
        vecs[7] = '{1'b1, 2'd3, 5'h00, 5'h00};
        vecs[8] = '{1'b0, 2'd3, 5'h00, 5'h00};

        // Reset with all pins high, then release
        gpio = 5'h1F;
        repeat (3) tick();
        check("rst_ack", W'(ack), W'(0));
        check("rst_rdt", rdt, 5'h00);
        rst_n = 1'b1;
        repeat (LAT + 4) tick();
        bus_read(2'd0, d); check("rst_state", d, 5'h1F);
        bus_read(2'd1, d); check("rst_rise", d, 5'h1F);
        bus_read(2'd2, d); check("rst_fall", d, 5'h00);
        check("rst_irq", W'(irq), W'(0));

        // Pins low, clear everything
        gpio = '0;
        repeat (LAT + 4) tick();
        bus_write(2'd1, 5'h1F);
        bus_write(2'd2, 5'h1F);
        bus_read(2'd1, d); check("clr_rise", d, 5'h00);
        bus_read(2'd2, d); check("clr_fall", d, 5'h00);

        // Register access table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].we) bus_write(vecs[i].adr, vecs[i].dat);
            else begin
                bus_read(vecs[i].adr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
        end

`ifdef SUBSERVIENT_GPIO_IN_DEBOUNCE_EN
        // Glitch shorter than the debounce window is rejected
        gpio[2] = 1'b1;
        repeat (D - 3) tick();
        gpio[2] = 1'b0;
        repeat (D + 6) tick();
        bus_read(2'd0, d); check("glitch_state", d & 5'h04, 5'h00);
        bus_read(2'd1, d); check("glitch_rise", d & 5'h04, 5'h00);
`endif

        latency_check(0);
        latency_check(2);

        // Falling edge interrupt and write-1-to-clear
        bus_write(2'd1, 5'h1F);
        check("int_irq_idle", W'(irq), W'(0));
        gpio[2] = 1'b0;
        repeat (LAT + 3) tick();
        bus_read(2'd2, d); check("int_fall", d, 5'h04);
        check("int_irq_on", W'(irq), W'(1));
        stb = 1'b1; we = 1'b1; adr = 2'd2; dat = 5'h04;
        tick();
        check("int_clr_ack", W'(ack), W'(1));
        check("int_irq_hold", W'(irq), W'(1));
        stb = 1'b0; we = 1'b0;
        tick();
        check("int_irq_off", W'(irq), W'(0));
        bus_read(2'd2, d); check("int_fall_clr", d, 5'h00);

        // Clear of RISE[1] in the very cycle the rise lands: set wins
        gpio[1] = 1'b1;
        repeat (LAT) tick();
        stb = 1'b1; we = 1'b1; adr = 2'd1; dat = 5'h02;
        tick();
        stb = 1'b0; we = 1'b0;
        tick();
        bus_read(2'd1, d); check("race_set_wins", d & 5'h02, 5'h02);
        bus_write(2'd1, 5'h02);
        bus_read(2'd1, d); check("race_later_clr", d & 5'h02, 5'h00);

        // Held strobe: ack alternates, one write per access
        stb = 1'b1; we = 1'b1; adr = 2'd3; dat = 5'h1B;
        check("hold_ack0", W'(ack), W'(0));
        for (int i = 1; i < 6; i++) begin
            tick();
            check($sformatf("hold_ack%0d", i), W'(ack), W'(i % 2));
        end
        stb = 1'b0; we = 1'b0;
        tick();
        bus_read(2'd3, d); check("hold_ien", d, 5'h1B);

        // Reset in the middle of an access drops ack immediately
        stb = 1'b1; we = 1'b0; adr = 2'd3;
        tick();
        check("mid_ack_up", W'(ack), W'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ack", W'(ack), W'(0));
        check("mid_rst_rdt", rdt, 5'h00);
        check("mid_rst_irq", W'(irq), W'(0));
        stb = 1'b0;
        gpio = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (LAT + 4) tick();
        bus_read(2'd1, d); check("post_rst_rise", d, 5'h00);
        bus_read(2'd2, d); check("post_rst_fall", d, 5'h00);
        bus_read(2'd3, d); check("post_rst_ien", d, 5'h00);

        // Random bus traffic and pin activity against the model
        for (int c = 0; c < 3000; c++) begin
            stb = ($urandom_range(0, 2) != 0);
            we  = 1'($urandom_range(0, 1));
            adr = 2'($urandom_range(0, 3));
            dat = W'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) begin
                b = $urandom_range(0, W - 1);
                gpio[b] = ~gpio[b];
            end
            tick();
        end
        stb = 1'b0; we = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
